// File: rtl/lsu_pkg.sv
// Shared CPU definitions for the load/store unit: FSM states, RV32I width codes
// and the store-side lane/alignment helpers.
package lsu_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } lsu_state_e;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Reserved width codes (011/110/111) are reported as misaligned.
  function automatic logic ls_aligned(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      LS_B, LS_BU: return 1'b1;
      LS_H, LS_HU: return ~lo[0];
      LS_W:        return (lo == 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ls_store_be(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      LS_B, LS_BU: return 4'b0001 << lo;
      LS_H, LS_HU: return 4'b0011 << lo;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ls_store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      LS_B, LS_BU: return {4{wdata[7:0]}};
      LS_H, LS_HU: return {2{wdata[15:0]}};
      default:     return wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Picks the addressed byte/half out of a raw read word and sign- or zero-extends
// it according to the load width code.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      LS_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LS_BU:   data_o = {24'h000000, byte_sel};
      LS_H:    data_o = {{16{half_sel[15]}}, half_sel};
      LS_HU:   data_o = {16'h0000, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: accepts one access from execute, holds the memory
// request until acknowledged, then returns a formatted result with a done pulse.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] load_data;

  load_extend u_load_extend (
    .word_i   (mem_rdata_i),
    .off_i    (addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (ls_aligned(funct3_i, addr_i[1:0])) begin
            addr_d   = addr_i;
            wdata_d  = wdata_i;
            we_d     = we_i;
            funct3_d = funct3_i;
            state_d  = ACCESS;
          end else begin
            done_d     = 1'b1;
            misalign_d = 1'b1;
            rdata_d    = 32'h0;
          end
        end
      end
      ACCESS: begin
        // Stores never expose whatever the memory drives on the read bus.
        if (mem_ack_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rdata_d = we_q ? 32'h0 : load_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
      rdata_q    <= rdata_d;
    end
  end

  assign busy_o      = (state_q == ACCESS);
  assign done_o      = done_q;
  assign misalign_o  = misalign_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = busy_o;
  assign mem_we_o    = busy_o & we_q;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_be_o    = we_q ? ls_store_be(funct3_q, addr_q[1:0]) : 4'b1111;
  assign mem_wdata_o = ls_store_data(funct3_q, wdata_q);

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic        busy_o, done_o, misalign_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  lsu dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .we_i        (we_i),
    .funct3_i    (funct3_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .misalign_o  (misalign_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: one outstanding transaction record plus the expected completion.
  bit          m_busy = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  bit          m_we = 1'b0;
  logic [2:0]  m_f3 = 3'b000;
  bit          e_done = 1'b0;
  bit          e_mis = 1'b0;
  logic [31:0] e_rdata = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return a % 2 == 0;
      3'd2:       return a % 4 == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a,
                                         input logic [2:0] f3);
    int          off = int'(a % 4);
    logic [31:0] b = (word >> (8 * off)) & 32'hFF;
    logic [31:0] h = (word >> (8 * off)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] m_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int off = int'(a % 4);
    if (!we) return 32'd15;
    case (f3)
      3'd0, 3'd4: return 32'd1 << off;
      3'd1, 3'd5: return 32'd3 << off;
      default:    return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0, 3'd4: return (wd & 32'hFF) * 32'h01010101;
      3'd1, 3'd5: return (wd & 32'hFFFF) * 32'h00010001;
      default:    return wd;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("busy", {31'h0, busy_o}, {31'h0, m_busy});
    chk("mem_req", {31'h0, mem_req_o}, {31'h0, m_busy});
    chk("mem_we", {31'h0, mem_we_o}, {31'h0, m_busy && m_we});
    chk("done", {31'h0, done_o}, {31'h0, e_done});
    chk("misalign", {31'h0, misalign_o}, {31'h0, e_mis});
    if (e_done) chk("rdata", rdata_o, e_rdata);
    if (m_busy) begin
      chk("mem_addr", mem_addr_o, m_addr & 32'hFFFFFFFC);
      chk("mem_be", {28'h0, mem_be_o}, m_be(m_we, m_f3, m_addr));
      if (m_we) chk("mem_wdata", mem_wdata_o, m_wd(m_f3, m_wdata));
    end
  end

  // One clock of stimulus; also advances the model to the state after the next edge.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] wd, input bit w,
                      input logic [2:0] f3, input bit ack, input logic [31:0] rd);
    @(negedge clk);
    #1;
    rst_i = 1'b0;
    valid_i = v; addr_i = a; wdata_i = wd; we_i = w; funct3_i = f3;
    mem_ack_i = ack; mem_rdata_i = rd;
    e_done = 1'b0;
    e_mis = 1'b0;
    if (m_busy) begin
      if (ack) begin
        m_busy = 1'b0;
        e_done = 1'b1;
        e_rdata = m_we ? 32'h0 : m_load(rd, m_addr, m_f3);
      end
    end else if (v) begin
      if (m_legal(f3, a)) begin
        m_busy = 1'b1; m_addr = a; m_wdata = wd; m_we = w; m_f3 = f3;
      end else begin
        e_done = 1'b1; e_mis = 1'b1; e_rdata = 32'h0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_i = 1'b1; valid_i = 1'b0; mem_ack_i = 1'b0;
    #1;
    chk("rst_req_now", {31'h0, mem_req_o}, 32'h0);
    chk("rst_busy_now", {31'h0, busy_o}, 32'h0);
    m_busy = 1'b0; e_done = 1'b0; e_mis = 1'b0;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] f3_tab [0:9] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd0, 3'd3, 3'd6, 3'd7};

  initial begin
    post();
    chk("reset_done", {31'h0, done_o}, 32'h0);
    chk("reset_busy", {31'h0, busy_o}, 32'h0);
    chk("reset_rdata", rdata_o, 32'h0);

    // LW, ack on first ACCESS cycle; valid driven in the first cycle after reset release.
    step(1, 32'h100, 32'h0, 0, 3'b010, 0, 32'h0);
    post();
    chk("lw_req", {31'h0, mem_req_o}, 32'h1);
    chk("lw_addr", mem_addr_o, 32'h100);
    chk("lw_be", {28'h0, mem_be_o}, 32'hF);
    step(0, 32'h0, 32'h0, 0, 3'b000, 1, 32'hDEADBEEF);
    post();
    chk("lw_done_c2", {31'h0, done_o}, 32'h1);
    chk("lw_rdata", rdata_o, 32'hDEADBEEF);

    step(1, 32'h103, 32'h0, 0, 3'b000, 0, 32'h0);
    step(0, 32'h0, 32'h0, 0, 3'b000, 1, 32'h80FF7F01);
    post();
    chk("lb_rdata", rdata_o, 32'hFFFFFF80);
    step(1, 32'h103, 32'h0, 0, 3'b100, 0, 32'h0);
    step(0, 32'h0, 32'h0, 0, 3'b000, 1, 32'h80FF7F01);
    post();
    chk("lbu_rdata", rdata_o, 32'h00000080);

    // SH with ack on the third ACCESS cycle.
    step(1, 32'h202, 32'h1234ABCD, 1, 3'b001, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      post();
      chk("sh_busy", {31'h0, busy_o}, 32'h1);
      chk("sh_addr", mem_addr_o, 32'h200);
      chk("sh_be", {28'h0, mem_be_o}, 32'hC);
      chk("sh_wdata", mem_wdata_o, 32'hABCDABCD);
      step(0, 32'h0, 32'h0, 0, 3'b000, i == 2, 32'hFFFFFFFF);
    end
    post();
    chk("sh_done", {31'h0, done_o}, 32'h1);
    chk("sh_rdata", rdata_o, 32'h0);
    step(0, 32'h0, 32'h0, 0, 3'b000, 0, 32'h0);
    post();
    chk("sh_done_once", {31'h0, done_o}, 32'h0);

    step(1, 32'h101, 32'h0, 0, 3'b010, 0, 32'h0);
    post();
    chk("mis_flag", {31'h0, misalign_o}, 32'h1);
    chk("mis_done", {31'h0, done_o}, 32'h1);
    chk("mis_rdata", rdata_o, 32'h0);
    chk("mis_noreq", {31'h0, mem_req_o}, 32'h0);
    step(0, 32'h0, 32'h0, 0, 3'b000, 1, 32'h0);
    post();
    chk("mis_noreq2", {31'h0, mem_req_o}, 32'h0);

    // Reset in the middle of an access, then a normal LW.
    step(1, 32'h300, 32'h0, 0, 3'b010, 0, 32'h0);
    post();
    chk("rst_pre_req", {31'h0, mem_req_o}, 32'h1);
    do_reset();
    step(1, 32'h304, 32'h0, 0, 3'b010, 0, 32'h0);
    step(0, 32'h0, 32'h0, 0, 3'b000, 1, 32'h55AA1234);
    post();
    chk("rst_after_lw", rdata_o, 32'h55AA1234);

    // SW then LW with valid held high through busy and done.
    step(1, 32'h400, 32'hCAFEF00D, 1, 3'b010, 0, 32'h0);
    post();
    chk("b2b_sw_addr", mem_addr_o, 32'h400);
    step(1, 32'h404, 32'h0, 0, 3'b010, 0, 32'h0);
    post();
    chk("b2b_ignored", mem_addr_o, 32'h400);
    step(1, 32'h404, 32'h0, 0, 3'b010, 1, 32'h0);
    post();
    chk("b2b_sw_done", {31'h0, done_o}, 32'h1);
    step(1, 32'h404, 32'h0, 0, 3'b010, 0, 32'h0);
    post();
    chk("b2b_lw_req", {31'h0, mem_req_o}, 32'h1);
    chk("b2b_lw_we", {31'h0, mem_we_o}, 32'h0);
    chk("b2b_lw_addr", mem_addr_o, 32'h404);
    step(0, 32'h0, 32'h0, 0, 3'b000, 1, 32'h11223344);
    post();
    chk("b2b_lw_rdata", rdata_o, 32'h11223344);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        logic [2:0] f3;
        bit         w;
        f3 = f3_tab[$urandom_range(0, 9)];
        w  = ($urandom_range(0, 1) == 1);
        if (w) f3[2] = 1'b0;
        step($urandom_range(0, 9) < 6, $urandom, $urandom, w, f3,
             $urandom_range(0, 9) < 4, $urandom);
      end
    end
    for (int n = 0; n < 3; n++) step(0, 32'h0, 32'h0, 0, 3'b000, 1, 32'h0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports clk_i and rst_i.
REQ-002 The ports SHALL be exactly the following:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  asynchronous, active-high reset
- valid_i  input  1  execute stage presents a load/store this cycle
- addr_i  input  32  effective address, the ALU result
- wdata_i  input  32  store data (rs2)
- we_i  input  1  1 = store, 0 = load
- funct3_i  input  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- busy_o  output  1  pipeline stall request
- done_o  output  1  one-cycle pulse, access complete
- rdata_o  output  32  formatted load result, valid while done_o=1
- misalign_o  output  1  one-cycle pulse, misaligned access rejected
- mem_req_o  output  1  memory request
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata_o  output  32  store data replicated to lanes
- mem_be_o  output  4  byte enables
- mem_ack_i  input  1  memory accepted write or returned read data
- mem_rdata_i  input  32  raw read word, valid with mem_ack_i

Function
REQ-003 FSM states SHALL be IDLE and ACCESS; busy_o = (state == ACCESS).
REQ-004 In IDLE with valid_i=1 and an aligned address, the block SHALL latch addr_i, wdata_i, we_i and funct3_i, then enter ACCESS on the next edge.
REQ-005 Alignment rules: W requires addr[1:0]=00; H/HU require addr[0]=0; B/BU are always aligned; funct3 011/110/111 SHALL be treated as misaligned.
REQ-006 On a misaligned valid_i in IDLE: stay IDLE; next cycle pulse misalign_o=1 and done_o=1 with rdata_o=0; no memory request.
REQ-007 In ACCESS, mem_req_o=1 and all mem_* outputs SHALL hold stable until the cycle in which mem_ack_i=1.
REQ-008 On mem_ack_i=1 in ACCESS: register the formatted rdata, return to IDLE, and pulse done_o=1 for exactly one cycle on the next cycle.
REQ-009 Latency: valid_i in cycle 0 gives mem_req_o in cycles 1..k, ack in cycle k, and done_o in cycle k+1. The minimum is done_o in cycle 2.
REQ-010 valid_i SHALL be ignored while busy_o=1.
REQ-011 A new valid_i SHALL be accepted in the same cycle that done_o is high.
REQ-012 Store lanes: mem_be_o = 0001<<addr[1:0] for B, 0011<<addr[1:0] for H, 1111 for W.
REQ-013 Store data: mem_wdata_o = {4{wdata[7:0]}} for B, {2{wdata[15:0]}} for H, and wdata for W.
REQ-014 Load formatting: select the byte or half by addr[1:0]; B/H sign-extend to 32 bits; BU/HU zero-extend; W passes through unchanged.
REQ-015 For loads, mem_be_o SHALL be 1111.
REQ-016 mem_rdata_i SHALL be ignored on stores; rdata_o on store completion SHALL be 0.
REQ-017 mem_ack_i outside ACCESS SHALL be ignored.

Reset
REQ-018 Asserting rst_i SHALL immediately force state=IDLE and set mem_req_o, busy_o, done_o and misalign_o to 0, and rdata_o and all latched fields to 0.
REQ-019 Reset during ACCESS SHALL abandon the access with no done_o.
REQ-020 The first valid_i is accepted in the first cycle after rst_i deasserts.

Structure
REQ-021 The state enum and the funct3 width constants (LS_B, LS_H, LS_W, LS_BU, LS_HU) SHALL live in the shared CPU package.
REQ-022 Load byte/half selection and extension SHALL be one combinational sub-module, load_extend.

Verification
REQ-023 LW addr=0x100, ack on first ACCESS cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, done_o in cycle 2, rdata_o=0xDEADBEEF.
REQ-024 LB addr=0x103 and LBU addr=0x103, mem_rdata=0x80FF7F01 -> rdata_o=0xFFFFFF80 and 0x00000080 respectively.
REQ-025 SH addr=0x202, wdata=0x1234ABCD, ack delayed 3 cycles -> be=1100, wdata_o=0xABCDABCD, mem_* stable 3 cycles, single done_o pulse, busy_o=1 throughout.
REQ-026 LW addr=0x101 -> misalign_o=1 and done_o=1 next cycle, mem_req_o never asserted.
REQ-027 rst_i asserted mid-ACCESS -> mem_req_o=0 immediately, no done_o; an LW after release completes normally.
REQ-028 Back-to-back SW then LW (valid_i held high through done_o) -> second access starts on the done_o cycle, and valid_i pulses during busy_o=1 are ignored.
